// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation scan controller.
package sar_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_SAMPLE_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } sar_state_e;

  // Channel-select width; a single-channel build still carries a 1-bit select.
  function automatic int cw_of(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/sar_scan_ctrl_if.sv
// Control, comparator and result signals of the SAR scan controller.
interface sar_scan_ctrl_if import sar_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) ();

  localparam int CW = cw_of(CHANNELS);

  logic             start_i;
  logic             cont_i;
  logic             abort_i;
  logic             cmp_i;
  logic             sample_o;
  logic [CW-1:0]    ch_o;
  logic [WIDTH-1:0] dac_o;
  logic [WIDTH-1:0] result_o;
  logic [CW-1:0]    result_ch_o;
  logic             valid_o;
  logic             eoc_o;
  logic             busy_o;

  modport slave (
    input  start_i, cont_i, abort_i, cmp_i,
    output sample_o, ch_o, dac_o, result_o, result_ch_o, valid_o, eoc_o, busy_o
  );

  modport master (
    output start_i, cont_i, abort_i, cmp_i,
    input  sample_o, ch_o, dac_o, result_o, result_ch_o, valid_o, eoc_o, busy_o
  );

endinterface

// File: rtl/sar_bit_engine.sv
// Binary-search bit engine: owns the DAC trial code, the bit index and the final code.
module sar_bit_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] dac_o,
  output logic [WIDTH-1:0] code_o,
  output logic             done_o
);

  localparam int             KW    = $clog2(WIDTH);
  localparam logic [KW-1:0]  K_TOP = KW'(WIDTH - 1);
  localparam logic [KW-1:0]  K_ONE = KW'(1);

  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] trial;
  logic [KW-1:0]    k_q, k_d;

  always_comb begin
    trial = dac_q;
    if (!cmp_i) trial[k_q] = 1'b0;

    dac_d  = dac_q;
    k_d    = k_q;
    code_d = code_q;
    done_o = 1'b0;

    if (clear_i) begin
      dac_d = '0;
      k_d   = K_TOP;
    end else if (load_i) begin
      dac_d          = '0;
      dac_d[WIDTH-1] = 1'b1;
      k_d            = K_TOP;
    end else if (step_i) begin
      if (k_q == '0) begin
        // LSB resolved: publish the code and park the DAC at zero.
        done_o = 1'b1;
        code_d = trial;
        dac_d  = '0;
        k_d    = K_TOP;
      end else begin
        dac_d              = trial;
        dac_d[k_q - K_ONE] = 1'b1;
        k_d                = k_q - K_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dac_q  <= '0;
      code_q <= '0;
      k_q    <= K_TOP;
    end else begin
      dac_q  <= dac_d;
      code_q <= code_d;
      k_q    <= k_d;
    end
  end

  assign dac_o  = dac_q;
  assign code_o = code_q;

endmodule

// File: rtl/sar_scan_ctrl.sv
// Multi-channel SAR scan controller: track/hold, bit-serial conversion, channel sequencing.
module sar_scan_ctrl import sar_pkg::*; #(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  sar_scan_ctrl_if.slave  bus
);

  localparam int            CW      = cw_of(CHANNELS);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [CW-1:0] CH_ONE  = CW'(1);
  localparam logic [3:0]    SC_LAST = 4'(SAMPLE_CYCLES - 1);

  sar_state_e       state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [CW-1:0]    res_ch_q, res_ch_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             eng_clear, eng_load, eng_step, eng_done;
  logic [WIDTH-1:0] eng_dac, eng_code;

  // Engine controls come straight from the registered state so eng_done never loops back.
  assign eng_clear = bus.abort_i;
  assign eng_load  = (state_q == ST_SAMPLE) && (cnt_q == SC_LAST) && !bus.abort_i;
  assign eng_step  = (state_q == ST_CONVERT) && !bus.abort_i;

  sar_bit_engine #(.WIDTH(WIDTH)) u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (eng_clear),
    .load_i  (eng_load),
    .step_i  (eng_step),
    .cmp_i   (bus.cmp_i),
    .dac_o   (eng_dac),
    .code_o  (eng_code),
    .done_o  (eng_done)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    res_ch_d = res_ch_q;

    if (bus.abort_i) begin
      state_d = ST_IDLE;
      ch_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_d = ST_SAMPLE;
            ch_d    = '0;
            cnt_d   = '0;
          end
        end
        ST_SAMPLE: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SC_LAST) state_d = ST_CONVERT;
        end
        ST_CONVERT: begin
          if (eng_done) begin
            state_d  = ST_DONE;
            res_ch_d = ch_q;
          end
        end
        ST_DONE: begin
          cnt_d = '0;
          if (ch_q != CH_LAST) begin
            state_d = ST_SAMPLE;
            ch_d    = ch_q + CH_ONE;
          end else if (bus.cont_i) begin
            state_d = ST_SAMPLE;
            ch_d    = '0;
          end else begin
            state_d = ST_IDLE;
            ch_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      res_ch_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      res_ch_q <= res_ch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.sample_o    = (state_q == ST_SAMPLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.valid_o     = (state_q == ST_DONE);
  assign bus.eoc_o       = (state_q == ST_DONE) && (ch_q == CH_LAST);
  assign bus.ch_o        = ch_q;
  assign bus.dac_o       = eng_dac;
  assign bus.result_o    = eng_code;
  assign bus.result_ch_o = res_ch_q;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench: a default 8-bit/4-channel controller and a 4-bit/1-channel build.
module tb_sar_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] vinA [4];
  logic [7:0] expA [4];
  logic [3:0] vinB;

  sar_scan_ctrl_if #(.WIDTH(8), .CHANNELS(4)) busA ();
  sar_scan_ctrl_if #(.WIDTH(4), .CHANNELS(1)) busB ();

  // Ideal comparators: each DUT sees its own analog input against its DAC.
  assign busA.cmp_i = (vinA[busA.ch_o] >= busA.dac_o);
  assign busB.cmp_i = (vinB >= busB.dac_o);

  sar_scan_ctrl #(.WIDTH(8), .CHANNELS(4), .SAMPLE_CYCLES(2)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  sar_scan_ctrl #(.WIDTH(4), .CHANNELS(1), .SAMPLE_CYCLES(2)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Inputs are applied 1 time unit after an edge and held for exactly one edge.
  task automatic applyStimulus(input logic st, input logic co, input logic ab);
    busA.start_i = st;
    busA.cont_i  = co;
    busA.abort_i = ab;
    waitCycles(1);
    busA.start_i = 1'b0;
    busA.abort_i = 1'b0;
  endtask

  task automatic collectValidsA(input string tag, input int nExpect, input int budget,
                                output int nSeen, output int idleSeen);
    nSeen    = 0;
    idleSeen = 0;
    for (int c = 0; c < budget && nSeen < nExpect; c++) begin
      waitCycles(1);
      if (!busA.busy_o) idleSeen++;
      if (busA.valid_o) begin
        checkOutput({tag, " result_ch"}, 32'(busA.result_ch_o), nSeen % 4);
        checkOutput({tag, " result"}, 32'(busA.result_o), 32'(expA[nSeen % 4]));
        checkOutput({tag, " eoc"}, 32'(busA.eoc_o), 32'((nSeen % 4) == 3));
        nSeen++;
      end
    end
  endtask

  task automatic fullScanA(input string tag);
    int n, idle;
    vinA = '{8'h00, 8'hFF, 8'h80, 8'h5A};
    expA = '{8'h00, 8'hFF, 8'h80, 8'h5A};
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, " sample after start"}, 32'(busA.sample_o), 1);
    checkOutput({tag, " busy after start"}, 32'(busA.busy_o), 1);
    checkOutput({tag, " ch after start"}, 32'(busA.ch_o), 0);
    checkOutput({tag, " dac in sample"}, 32'(busA.dac_o), 0);
    collectValidsA(tag, 4, 60, n, idle);
    checkOutput({tag, " valid count"}, n, 4);
    checkOutput({tag, " idle during scan"}, idle, 0);
    waitCycles(1);
    checkOutput({tag, " busy after scan"}, 32'(busA.busy_o), 0);
    checkOutput({tag, " valid after scan"}, 32'(busA.valid_o), 0);
    checkOutput({tag, " result held"}, 32'(busA.result_o), 32'h5A);
    checkOutput({tag, " result_ch held"}, 32'(busA.result_ch_o), 3);
  endtask

  task automatic runB(input string tag, input logic [3:0] v, input logic [3:0] exp);
    int cyc;
    vinB = v;
    busB.start_i = 1'b1;
    waitCycles(1);
    busB.start_i = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busB.valid_o) begin
        cyc = c;
        break;
      end
      waitCycles(1);
    end
    checkOutput({tag, " valid cycle"}, cyc, 7);
    checkOutput({tag, " result"}, 32'(busB.result_o), 32'(exp));
    checkOutput({tag, " eoc with valid"}, 32'(busB.eoc_o), 1);
    checkOutput({tag, " result_ch"}, 32'(busB.result_ch_o), 0);
    waitCycles(1);
    checkOutput({tag, " idle after"}, 32'(busB.busy_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] dacExp [10];
    int  n, idle, idle2, cyc;
    logic sawActivity;

    busA.start_i = 1'b0;
    busA.cont_i  = 1'b0;
    busA.abort_i = 1'b0;
    busB.start_i = 1'b0;
    busB.cont_i  = 1'b0;
    busB.abort_i = 1'b0;
    vinA = '{8'h00, 8'h00, 8'h00, 8'h00};
    expA = '{8'h00, 8'h00, 8'h00, 8'h00};
    vinB = 4'h0;

    waitCycles(2);
    checkOutput("reset sample", 32'(busA.sample_o), 0);
    checkOutput("reset busy", 32'(busA.busy_o), 0);
    checkOutput("reset valid", 32'(busA.valid_o), 0);
    checkOutput("reset dac", 32'(busA.dac_o), 0);
    checkOutput("reset result", 32'(busA.result_o), 0);
    rst_n = 1'b1;
    waitCycles(1);

    fullScanA("scan1");

    // Single conversion of 0x5A: trial codes walk the binary search.
    vinA = '{8'h5A, 8'h00, 8'h00, 8'h00};
    dacExp = '{8'h00, 8'h00, 8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
    applyStimulus(1'b1, 1'b0, 1'b0);
    cyc = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 10) checkOutput($sformatf("trace dac c%0d", c), 32'(busA.dac_o), 32'(dacExp[c-1]));
      if (busA.valid_o && cyc == 0) cyc = c;
      if (c < 11) waitCycles(1);
    end
    checkOutput("trace valid cycle", cyc, 11);
    checkOutput("trace result", 32'(busA.result_o), 32'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("trace next ch", 32'(busA.ch_o), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort sample busy", 32'(busA.busy_o), 0);
    checkOutput("abort sample result held", 32'(busA.result_o), 32'h5A);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("abort beats start", 32'(busA.busy_o), 0);

    // Continuous mode: two full scans back to back, then drop cont mid-scan.
    vinA = '{8'h11, 8'h22, 8'h33, 8'h44};
    expA = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b1, 1'b1, 1'b0);
    collectValidsA("cont", 8, 200, n, idle);
    checkOutput("cont valids", n, 8);
    checkOutput("cont idle", idle, 0);
    waitCycles(1);
    checkOutput("cont rescan sample", 32'(busA.sample_o), 1);
    checkOutput("cont rescan ch", 32'(busA.ch_o), 0);
    waitCycles(3);
    busA.cont_i = 1'b0;
    collectValidsA("cont-drop", 4, 100, n, idle2);
    checkOutput("cont-drop valids", n, 4);
    checkOutput("cont-drop idle", idle2, 0);
    waitCycles(1);
    checkOutput("cont-drop stops", 32'(busA.busy_o), 0);

    // Abort during conversion of channel 2; starts while busy are ignored.
    vinA = '{8'h10, 8'h20, 8'h30, 8'h40};
    expA = '{8'h10, 8'h20, 8'h30, 8'h40};
    applyStimulus(1'b1, 1'b0, 1'b0);
    collectValidsA("abort", 2, 40, n, idle);
    checkOutput("abort pre valids", n, 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("busy start ignored ch", 32'(busA.ch_o), 2);
    checkOutput("busy start ignored sample", 32'(busA.sample_o), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("convert entry dac", 32'(busA.dac_o), 32'h80);
    checkOutput("convert entry ch", 32'(busA.ch_o), 2);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort busy", 32'(busA.busy_o), 0);
    checkOutput("abort valid", 32'(busA.valid_o), 0);
    checkOutput("abort ch", 32'(busA.ch_o), 0);
    checkOutput("abort dac", 32'(busA.dac_o), 0);
    checkOutput("abort result held", 32'(busA.result_o), 32'h20);
    checkOutput("abort result_ch held", 32'(busA.result_ch_o), 1);
    sawActivity = 1'b0;
    for (int c = 0; c < 15; c++) begin
      waitCycles(1);
      if (busA.valid_o || busA.busy_o) sawActivity = 1'b1;
    end
    checkOutput("abort stays idle", 32'(sawActivity), 0);

    // Reset for one cycle in the middle of SAMPLE.
    applyStimulus(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    checkOutput("midreset sample", 32'(busA.sample_o), 0);
    checkOutput("midreset busy", 32'(busA.busy_o), 0);
    checkOutput("midreset valid", 32'(busA.valid_o), 0);
    checkOutput("midreset eoc", 32'(busA.eoc_o), 0);
    checkOutput("midreset ch", 32'(busA.ch_o), 0);
    checkOutput("midreset result_ch", 32'(busA.result_ch_o), 0);
    checkOutput("midreset dac", 32'(busA.dac_o), 0);
    checkOutput("midreset result", 32'(busA.result_o), 0);
    fullScanA("scan2");

    runB("b-full", 4'hF, 4'hF);
    runB("b-zero", 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_scan_ctrl.md
SAR_SCAN_CTRL -- requirements
Module: sar_scan_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: converter resolution in bits, legal range 2..16.
REQ-002 The block SHALL have parameter CHANNELS, default 4: analog channels per scan, legal range 1..16.
REQ-003 The block SHALL have parameter SAMPLE_CYCLES, default 2: duration of the track/hold phase in clock cycles, legal range 1..15.
REQ-004 Derived constant CW = max(1, clog2(CHANNELS)).
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port start_i, input, 1: starts a scan; sampled only in IDLE.
REQ-008 Port cont_i, input, 1: continuous mode; when 1, a new scan starts after each completed scan.
REQ-009 Port abort_i, input, 1: aborts any operation in progress.
REQ-010 Port cmp_i, input, 1: comparator output; 1 means Vin >= DAC voltage.
REQ-011 Port sample_o, output, 1: track/hold control, high during SAMPLE.
REQ-012 Port ch_o, output, CW: mux select for the channel currently in SAMPLE or CONVERT.
REQ-013 Port dac_o, output, WIDTH: trial code driven to the DAC.
REQ-014 Port result_o, output, WIDTH: last completed conversion result; holds between conversions.
REQ-015 Port result_ch_o, output, CW: channel index of result_o.
REQ-016 Port valid_o, output, 1: one-cycle pulse marking a new result_o/result_ch_o.
REQ-017 Port eoc_o, output, 1: one-cycle pulse, coincident with valid_o of the last channel in a scan.
REQ-018 Port busy_o, output, 1: high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, SAMPLE, CONVERT and DONE.
REQ-020 IDLE with start_i=1 SHALL go to SAMPLE with ch_o=0; start_i SHALL be ignored in all other states.
REQ-021 SAMPLE SHALL last exactly SAMPLE_CYCLES cycles with sample_o=1 and dac_o=0, then go to CONVERT.
REQ-022 On entry to CONVERT, dac_o SHALL equal 1<<(WIDTH-1) and the bit index k SHALL equal WIDTH-1.
REQ-023 In each CONVERT cycle, if cmp_i=0, bit k of dac_o SHALL be cleared.
REQ-024 In each CONVERT cycle with k>0, bit k-1 SHALL be set and k decremented.
REQ-025 The CONVERT cycle with k=0 SHALL go to DONE, so CONVERT lasts exactly WIDTH cycles.
REQ-026 In DONE (1 cycle), result_o SHALL equal the final code, result_ch_o SHALL equal ch_o, and valid_o SHALL be 1.
REQ-027 Latency: valid_o SHALL assert SAMPLE_CYCLES+WIDTH+1 cycles after the edge that accepted start_i.
REQ-028 DONE with ch_o<CHANNELS-1 SHALL go to SAMPLE with ch_o+1.
REQ-029 DONE with ch_o=CHANNELS-1 SHALL assert eoc_o.
REQ-030 After eoc_o, the block SHALL go to SAMPLE with ch_o=0 if cont_i=1, else to IDLE; cont_i SHALL be sampled only at that point.
REQ-031 abort_i=1 in any state SHALL force IDLE on the next edge with no valid_o/eoc_o, ch_o=0, dac_o=0, and result_o held.
REQ-032 abort_i SHALL take priority over start_i and over DONE transitions.
REQ-033 With CHANNELS=1, every DONE SHALL assert both valid_o and eoc_o.
REQ-034 Codes SHALL be unsigned; a constant cmp_i=1 SHALL give all ones and a constant cmp_i=0 SHALL give all zeros.

Reset
REQ-035 With rst_n=0 at an edge, the block SHALL enter IDLE, overriding all inputs.
REQ-036 Reset SHALL clear sample_o, valid_o, eoc_o, busy_o, ch_o, result_ch_o, dac_o and result_o to 0, including when applied mid-conversion.

Structure
REQ-037 Package sar_pkg SHALL hold the state enumeration and the default constants for WIDTH, CHANNELS and SAMPLE_CYCLES.
REQ-038 Sub-module sar_bit_engine (WIDTH) SHALL own dac_o, the bit index k and the final-code register.
REQ-039 sar_bit_engine SHALL have load/step/done handshakes.
REQ-040 The top level SHALL own the FSM, sample counter, channel counter and result registers.

Verification (WIDTH=8, CHANNELS=4, SAMPLE_CYCLES=2, comparator model cmp_i = Vin[ch_o] >= dac_o)
REQ-041 Vin={0x00,0xFF,0x80,0x5A}, start pulse, cont_i=0 -> four valid_o pulses, results 0x00,0xFF,0x80,0x5A on ch 0..3, eoc_o with ch 3, then IDLE and busy_o=0.
REQ-042 Single start, Vin[0]=0x5A -> valid_o exactly 11 cycles after the start edge; dac_o sequence 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A,0x5B.
REQ-043 cont_i=1 held -> back-to-back scans with no IDLE cycle; cont_i dropped mid-scan -> current scan completes, then IDLE.
REQ-044 abort_i during CONVERT of ch 2 -> IDLE next cycle, no valid_o, result_o keeps the ch 1 value; start_i pulses during busy_o have no effect.
REQ-045 rst_n=0 for 1 cycle mid-SAMPLE -> all outputs 0 next cycle; a new start after reset behaves exactly as in REQ-041.
REQ-046 CHANNELS=1, WIDTH=4 build -> valid_o and eoc_o coincide; Vin=0xF gives 0xF and Vin=0x0 gives 0x0.
